// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole board front end.
package whack_pkg;

    localparam int unsigned NUM_POS = 8;
    localparam int unsigned POS_W   = 3;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        GUESSED
    } state_e;

    // Priority encoder: index of the lowest set bit (bit 0 wins). Returns 0 for an empty vector.
    function automatic logic [POS_W-1:0] lowest_set(input logic [NUM_POS-1:0] v);
        logic [POS_W-1:0] idx;
        idx = '0;
        for (int i = NUM_POS - 1; i >= 0; i--) begin
            if (v[i]) idx = POS_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus a single shared debounce counter for a button vector.
// The whole vector must stay unchanged for DEBOUNCE_CYCLES before it is accepted.
module btn_debounce #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] stable
);

    localparam int unsigned         CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] sync2_d;
    logic [CNT_W-1:0] cnt;

    // Synchroniser chain and one-cycle delayed copy used for change detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            sync2_d <= '0;
        end else begin
            sync1   <= din;
            sync2   <= sync1;
            sync2_d <= sync2;
        end
    end

    // Shared counter: any bit change restarts it; saturates once the vector has settled.
    // The equality guard keeps a just-changed vector from being accepted on a stale count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            stable <= '0;
        end else begin
            if (sync2 != sync2_d) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            if (sync2 == sync2_d && cnt == CNT_MAX) begin
                stable <= sync2;
            end
        end
    end

endmodule

// File: rtl/guess_input_ctrl.sv
// Board front end: debounced buttons -> first new press per round -> guess/eval strobes.
module guess_input_ctrl
    import whack_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned ROUND_CYCLES    = 100000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_POS-1:0] btn_raw,
    input  logic               mole_change,
    output logic [POS_W-1:0]   user_guess,
    output logic               guess_now,
    output logic               eval_now
);

    localparam int unsigned      TMR_W    = $clog2(ROUND_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ROUND_CYCLES - 1);

    logic [NUM_POS-1:0] stable;
    logic [NUM_POS-1:0] stable_d;
    logic [NUM_POS-1:0] rise;
    logic               expired;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [POS_W-1:0]   user_guess_q, user_guess_d;
    logic               guess_now_q, guess_now_d;
    logic               eval_now_q, eval_now_d;

    btn_debounce #(
        .WIDTH           (NUM_POS),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk    (clk),
        .rst    (rst),
        .din    (btn_raw),
        .stable (stable)
    );

    // Only rising edges count, so a button held across a round boundary never guesses.
    assign rise    = stable & ~stable_d;
    assign expired = (timer_q == TMR_LAST);

    // State, timer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_d     <= '0;
            state_q      <= IDLE;
            timer_q      <= '0;
            user_guess_q <= '0;
            guess_now_q  <= 1'b0;
            eval_now_q   <= 1'b0;
        end else begin
            stable_d     <= stable;
            state_q      <= state_d;
            timer_q      <= timer_d;
            user_guess_q <= user_guess_d;
            guess_now_q  <= guess_now_d;
            eval_now_q   <= eval_now_d;
        end
    end

    // Round FSM: accept first rise while ARMED, close the round on expiry; mole_change restarts.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        user_guess_d = user_guess_q;
        guess_now_d  = 1'b0;
        eval_now_d   = 1'b0;

        case (state_q)
            IDLE: begin
            end
            ARMED: begin
                timer_d = timer_q + 1'b1;
                if (|rise) begin
                    user_guess_d = lowest_set(rise);
                    guess_now_d  = 1'b1;
                    state_d      = GUESSED;
                end
                if (expired) begin
                    eval_now_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            GUESSED: begin
                timer_d = timer_q + 1'b1;
                if (expired) begin
                    eval_now_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new round always wins; an expiry in the same cycle has already pulsed eval_now.
        if (mole_change) begin
            state_d = ARMED;
            timer_d = '0;
        end
    end

    assign user_guess = user_guess_q;
    assign guess_now  = guess_now_q;
    assign eval_now   = eval_now_q;

endmodule

// File: doc/guess_input_ctrl.md
# guess_input_ctrl

Board-side front end that drives the guess/evaluate interface of the whack-a-mole game core. It synchronises and debounces eight raw mole buttons and encodes the first new press of each round into `user_guess`. It then strobes `guess_now` and closes each round with an `eval_now` strobe. Rounds are timed from the core's `mole_change` output.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 500000: cycles the synchronised button vector must hold unchanged before it is accepted. Minimum 2.
- `ROUND_CYCLES`, 100000000: guess-window length in cycles, counted from `mole_change`. Minimum 2.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- `clk` in, 1: system clock.
- `rst` in, 1: asynchronous, active-high reset.
- `btn_raw` in, 8: raw, asynchronous, bouncing buttons. Bit i is mole position i; active-high.
- `mole_change` in, 1: one-cycle pulse from the core marking the start of a new round.
- `user_guess` out, 3: encoded position of the accepted press. Valid with `guess_now`; holds until the next accepted press.
- `guess_now` out, 1: one-cycle strobe; a guess was accepted this round.
- `eval_now` out, 1: one-cycle strobe; the round window has expired.

## Operation
- Reset values: `user_guess`=0, `guess_now`=0, `eval_now`=0. All sync, debounce and timer registers are 0. FSM is in IDLE.
- Reset mid-round: the round is abandoned and no `eval_now` is emitted. The block waits in IDLE for the next `mole_change`.
- Synchroniser: two flops per bit give `sync2`. A third register gives `sync2_d`.
- Debounce (one shared counter for the whole vector):
  - Counter clears when `sync2 != sync2_d`; otherwise it increments, saturating.
  - When the counter equals `DEBOUNCE_CYCLES-1`, `stable <= sync2`.
  - Any bit change restarts the counter for all bits.
- Edge detect: `rise = stable & ~stable_d`. Only rising edges count, so a button held across a round boundary is never a guess.
- Multiple simultaneous rises: the lowest index wins (priority encode from bit 0). The other rises in that cycle are discarded.
- FSM:
  - IDLE: waits for `mole_change`, then goes to ARMED.
  - ARMED: on a nonzero `rise`, latches `user_guess`, pulses `guess_now`, and goes to GUESSED.
  - GUESSED: ignores `rise`.
  - ARMED and GUESSED: on timer expiry, pulse `eval_now` and go to IDLE.
- Round timer:
  - Loads 0 on `mole_change` and increments in ARMED/GUESSED.
  - Expiry is when the timer equals `ROUND_CYCLES-1`.
  - Counter width is `$clog2(ROUND_CYCLES)`.
- `mole_change` while in ARMED/GUESSED: the round restarts (timer reloads, state goes to ARMED). No `eval_now` is emitted for the abandoned round.
- `mole_change` in the same cycle as expiry: `eval_now` still pulses, and the next state is ARMED with the timer reloaded.
- `rise` in the same cycle as expiry while ARMED: the guess is accepted. `guess_now` and `eval_now` both pulse in that cycle.
- If no press occurs in a round, `eval_now` pulses, `guess_now` never pulses, and `user_guess` keeps its prior value.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Press latency: let N be the first edge at which `btn_raw[i]` is sampled high, and assume the button is stable from then on. Then:
  - `stable[i]` rises at edge N+D+2, where D = `DEBOUNCE_CYCLES`.
  - `guess_now` is high for exactly one cycle after edge N+D+3, provided the FSM is ARMED at that point.
- Round timing: with `mole_change` high in the cycle before edge M, `eval_now` is high for the one cycle after edge M+`ROUND_CYCLES`.
- Strobes never exceed one cycle. At most one `guess_now` per round.

## Structure
- Shared package `whack_pkg` holds:
  - the FSM state enum: IDLE, ARMED, GUESSED;
  - `NUM_POS`=8;
  - `POS_W`=3.
- Natural sub-module: `btn_debounce`. It contains the synchroniser, the debounce counter and the `stable` register, is parameterised by width and `DEBOUNCE_CYCLES`, and outputs `stable`.
- Top level holds the edge detect, priority encoder, FSM and round timer.

## Test plan
All scenarios use D=4 and R=20.
- Reset values: assert `rst` mid-round. Outputs must be 0 immediately. After release, no `eval_now` appears until a new `mole_change` plus 20 cycles.
- Clean press: `mole_change`, then `btn_raw`=8'h20 held. Expect `user_guess`=5 and a one-cycle `guess_now` exactly D+3=7 edges after the first high sample. Expect `eval_now` 20 edges after the `mole_change`.
- Bounce: toggle bit 2 every 2 cycles for 10 cycles, then hold. Expect exactly one `guess_now` with `user_guess`=2, timed 7 edges after the final toggle.
- Simultaneous and second presses: `btn_raw`=8'h48 gives `user_guess`=3. Release and press 8'h80 in the same round. Expect no second `guess_now`.
- Held across rounds: hold 8'h01 through the next `mole_change`. Expect no `guess_now` in the new round. Its `eval_now` still fires and `user_guess` is unchanged.
- Mid-round restart: a second `mole_change` at cycle 10 of a round. Expect no `eval_now` at cycle 20 and `eval_now` 20 edges after the second pulse.
